// File: rtl/pipeline_pkg.sv
// pipeline_pkg: stage indices, result-source and forward-select codes for the 5-stage core
package pipeline_pkg;
  localparam int STG_IF = 0, STG_ID = 1, STG_EX = 2, STG_MA = 3, STG_WB = 4;
  localparam logic [1:0] RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2;
  localparam logic [1:0] FWD_NONE = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: EX operand forward select for one source register
module fwd_sel
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] ma_rd_addr,
  input  logic              ma_we,
  input  logic [1:0]        ma_res_src,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_we,
  output logic [1:0]        sel
);
  assign sel = (rs_addr == '0) ? FWD_NONE :
               (ma_we && rs_addr == ma_rd_addr && ma_res_src != RES_MEM) ? FWD_MEM :
               (wb_we && rs_addr == wb_rd_addr) ? FWD_WB : FWD_NONE;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, forwarding, multi-cycle hold, memory-wait and redirect control for the 5-stage core
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_LATENCY = 4,
  parameter int STAT_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rs1_addr,
  input  logic [REG_AW-1:0] ex_rs2_addr,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic              ex_rd_write_enable,
  input  logic [1:0]        ex_res_src,
  input  logic              ex_mc_op,
  input  logic              ex_pc_src,
  input  logic [31:0]       ex_target_pc,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_rd_write_enable,
  input  logic [1:0]        mem_res_src,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_rd_write_enable,
  input  logic              imem_ready,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic [4:0]        stall,
  output logic [4:0]        flush,
  output logic [1:0]        forward_rs1,
  output logic [1:0]        forward_rs2,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] redirect_count
);
  localparam int MCW = MC_LATENCY > 1 ? $clog2(MC_LATENCY) : 1;
  logic [MCW-1:0] mc_cnt;
  logic           redir_pend;
  logic [31:0]    pend_pc;
  logic           dmem_wait, mc_hold, take, load_use, imem_wait;
  logic           hold_ex, hold_id, hold_if, deliver;
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr(ex_rs1_addr), .ma_rd_addr(mem_rd_addr), .ma_we(mem_rd_write_enable),
    .ma_res_src(mem_res_src), .wb_rd_addr(wb_rd_addr), .wb_we(wb_rd_write_enable), .sel(forward_rs1)
  );
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr(ex_rs2_addr), .ma_rd_addr(mem_rd_addr), .ma_we(mem_rd_write_enable),
    .ma_res_src(mem_res_src), .wb_rd_addr(wb_rd_addr), .wb_we(wb_rd_write_enable), .sel(forward_rs2)
  );
  assign dmem_wait = dmem_req & ~dmem_ready;
  assign mc_hold   = ex_mc_op & (mc_cnt != MCW'(MC_LATENCY - 1));
  assign take      = ex_pc_src & ~(dmem_wait | mc_hold);
  // The instruction in ID is wrong-path when EX redirects, so it needs no load-use bubble
  assign load_use  = ~take & (ex_res_src == RES_MEM) & ex_rd_write_enable & (ex_rd_addr != '0) &
                     ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) | (id_rs2_used & (id_rs2_addr == ex_rd_addr)));
  assign imem_wait = ~imem_ready;
  assign hold_ex   = dmem_wait | mc_hold;
  assign hold_id   = hold_ex | load_use;
  assign hold_if   = hold_id | imem_wait;
  assign stall     = {dmem_wait, dmem_wait, hold_ex, hold_id, hold_if};
  // A redirect squashes IF even while fetch waits on imem; the target then stays pending
  assign flush     = {1'b0, mc_hold & ~dmem_wait, load_use & ~hold_ex, take | (imem_wait & ~hold_id), take};
  assign redirect_valid = take | redir_pend;
  assign redirect_pc    = take ? ex_target_pc : pend_pc;
  assign deliver        = redirect_valid & ~hold_if;
  always_ff @(posedge clk) begin
    if (reset) begin
      mc_cnt         <= '0;
      redir_pend     <= 1'b0;
      pend_pc        <= '0;
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      mc_cnt         <= (ex_mc_op & hold_ex) ? mc_cnt + MCW'(mc_hold) : '0;
      redir_pend     <= redirect_valid & hold_if;
      pend_pc        <= (take & hold_if) ? ex_target_pc : pend_pc;
      stall_cycles   <= stall_cycles + STAT_W'(hold_if & ~&stall_cycles);
      redirect_count <= redirect_count + STAT_W'(deliver & ~&redirect_count);
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table vectors, corner-case sequences and randomized checking against a rule-level model
module tb_pipeline_ctrl;
  import pipeline_pkg::*;
  localparam int MCL = 4;
  localparam int SMAX = 15;
  typedef struct {
    logic [4:0] r1, r2, exr1, exr2, exrd, mrd, wrd;
    logic u1, u2, exwe, mc, br, mwe, wwe, imr, dreq, drdy;
    logic [1:0] exsrc, msrc;
    logic [31:0] tgt;
  } in_t;
  typedef struct {
    in_t i;
    logic [4:0] st, fl;
    logic [1:0] f1, f2;
    logic rv;
  } vec_t;
  typedef struct {
    logic [4:0] st, fl;
    logic [1:0] f1, f2;
    logic rv;
    logic [31:0] rpc;
  } out_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic id_rs1_used, id_rs2_used, ex_rd_write_enable, ex_mc_op, ex_pc_src, mem_rd_write_enable;
  logic wb_rd_write_enable, imem_ready, dmem_req, dmem_ready;
  logic [1:0] ex_res_src, mem_res_src, forward_rs1, forward_rs2;
  logic [31:0] ex_target_pc, redirect_pc;
  logic [4:0] stall, flush;
  logic redirect_valid;
  logic [3:0] stall_cycles, redirect_count;
  int n_chk = 0, n_pass = 0;
  int m_cnt, m_sc, m_rc;
  bit m_pend;
  logic [31:0] m_pc;

  pipeline_ctrl #(.REG_AW(5), .MC_LATENCY(MCL), .STAT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_rd_write_enable(ex_rd_write_enable), .ex_res_src(ex_res_src), .ex_mc_op(ex_mc_op),
    .ex_pc_src(ex_pc_src), .ex_target_pc(ex_target_pc),
    .mem_rd_addr(mem_rd_addr), .mem_rd_write_enable(mem_rd_write_enable), .mem_res_src(mem_res_src),
    .wb_rd_addr(wb_rd_addr), .wb_rd_write_enable(wb_rd_write_enable),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall(stall), .flush(flush), .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cycles(stall_cycles), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  function automatic in_t quiet();
    in_t x;
    x = '{r1:0, r2:0, exr1:0, exr2:0, exrd:0, mrd:0, wrd:0, u1:0, u2:0, exwe:0, mc:0, br:0,
          mwe:0, wwe:0, imr:1, dreq:0, drdy:0, exsrc:0, msrc:0, tgt:0};
    return x;
  endfunction

  task automatic apply(in_t x, logic r);
    @(negedge clk);
    reset = r;
    id_rs1_addr = x.r1; id_rs2_addr = x.r2; id_rs1_used = x.u1; id_rs2_used = x.u2;
    ex_rs1_addr = x.exr1; ex_rs2_addr = x.exr2; ex_rd_addr = x.exrd; ex_rd_write_enable = x.exwe;
    ex_res_src = x.exsrc; ex_mc_op = x.mc; ex_pc_src = x.br; ex_target_pc = x.tgt;
    mem_rd_addr = x.mrd; mem_rd_write_enable = x.mwe; mem_res_src = x.msrc;
    wb_rd_addr = x.wrd; wb_rd_write_enable = x.wwe;
    imem_ready = x.imr; dmem_req = x.dreq; dmem_ready = x.drdy;
    #1;
  endtask

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
  endtask

  function automatic logic [1:0] mfwd(logic [4:0] rs, in_t x);
    if (rs == 0) return FWD_NONE;
    if (x.mwe && x.mrd == rs && x.msrc != RES_MEM) return FWD_MEM;
    if (x.wwe && x.wrd == rs) return FWD_WB;
    return FWD_NONE;
  endfunction

  function automatic out_t model(in_t x);
    out_t o;
    bit dw, mh, tk, lu, iw;
    dw = x.dreq && !x.drdy;
    mh = x.mc && m_cnt < MCL - 1;
    tk = x.br && !dw && !mh;
    lu = !tk && x.exsrc == RES_MEM && x.exwe && x.exrd != 0 &&
         ((x.u1 && x.r1 == x.exrd) || (x.u2 && x.r2 == x.exrd));
    iw = !x.imr;
    for (int s = 0; s < 5; s++) o.st[s] = dw || (mh && s <= 2) || (lu && s <= 1) || (iw && s == 0);
    o.fl[0] = tk;
    o.fl[1] = tk || (iw && !o.st[1]);
    o.fl[2] = lu && !o.st[2];
    o.fl[3] = mh && !o.st[3];
    o.fl[4] = 1'b0;
    o.f1 = mfwd(x.exr1, x);
    o.f2 = mfwd(x.exr2, x);
    o.rv = tk || m_pend;
    o.rpc = tk ? x.tgt : m_pc;
    return o;
  endfunction

  task automatic model_clk(in_t x, out_t o, logic r);
    bit tk;
    if (r) begin
      m_cnt = 0; m_pend = 0; m_pc = 0; m_sc = 0; m_rc = 0;
    end else begin
      tk = x.br && !o.st[2];
      if (o.st[0] && m_sc < SMAX) m_sc++;
      if (o.rv && !o.st[0] && m_rc < SMAX) m_rc++;
      if (tk && o.st[0]) begin m_pend = 1; m_pc = x.tgt; end
      else if (!o.st[0]) m_pend = 0;
      m_cnt = (x.mc && o.st[2]) ? (m_cnt < MCL - 1 ? m_cnt + 1 : m_cnt) : 0;
    end
  endtask

  initial begin
    vec_t tv[$];
    in_t t, x;
    out_t o;
    logic r;
    t = quiet(); t.exr1 = 5; t.mrd = 5; t.mwe = 1;
    tv.push_back('{t, 5'b00000, 5'b00000, FWD_MEM, FWD_NONE, 1'b0});
    t.wrd = 5; t.wwe = 1;
    tv.push_back('{t, 5'b00000, 5'b00000, FWD_MEM, FWD_NONE, 1'b0});
    t = quiet(); t.mwe = 1; t.wwe = 1;
    tv.push_back('{t, 5'b00000, 5'b00000, FWD_NONE, FWD_NONE, 1'b0});
    t = quiet(); t.exr2 = 7; t.mrd = 7; t.mwe = 1; t.msrc = RES_MEM; t.wrd = 7; t.wwe = 1;
    tv.push_back('{t, 5'b00000, 5'b00000, FWD_NONE, FWD_WB, 1'b0});
    t = quiet(); t.exrd = 6; t.exwe = 1; t.exsrc = RES_MEM; t.r1 = 6; t.u1 = 1;
    tv.push_back('{t, 5'b00011, 5'b00100, FWD_NONE, FWD_NONE, 1'b0});
    t.u1 = 0;
    tv.push_back('{t, 5'b00000, 5'b00000, FWD_NONE, FWD_NONE, 1'b0});
    t = quiet(); t.exwe = 1; t.exsrc = RES_MEM; t.u1 = 1;
    tv.push_back('{t, 5'b00000, 5'b00000, FWD_NONE, FWD_NONE, 1'b0});
    t = quiet(); t.imr = 0;
    tv.push_back('{t, 5'b00001, 5'b00010, FWD_NONE, FWD_NONE, 1'b0});
    t = quiet(); t.exrd = 6; t.exwe = 1; t.exsrc = RES_MEM; t.r2 = 6; t.u2 = 1; t.imr = 0;
    tv.push_back('{t, 5'b00011, 5'b00100, FWD_NONE, FWD_NONE, 1'b0});
    t = quiet(); t.dreq = 1; t.br = 1; t.tgt = 32'h40;
    tv.push_back('{t, 5'b11111, 5'b00000, FWD_NONE, FWD_NONE, 1'b0});
    t.drdy = 1;
    tv.push_back('{t, 5'b00000, 5'b00011, FWD_NONE, FWD_NONE, 1'b1});
    t = quiet(); t.br = 1; t.exrd = 6; t.exwe = 1; t.exsrc = RES_MEM; t.r1 = 6; t.u1 = 1;
    tv.push_back('{t, 5'b00000, 5'b00011, FWD_NONE, FWD_NONE, 1'b1});
    t = quiet(); t.mc = 1; t.br = 1;
    tv.push_back('{t, 5'b00111, 5'b01000, FWD_NONE, FWD_NONE, 1'b0});
    foreach (tv[k]) begin
      apply(quiet(), 1'b1);
      apply(tv[k].i, 1'b0);
      chk($sformatf("tv%0d stall", k), stall, tv[k].st);
      chk($sformatf("tv%0d flush", k), flush, tv[k].fl);
      chk($sformatf("tv%0d fwd1", k), forward_rs1, tv[k].f1);
      chk($sformatf("tv%0d fwd2", k), forward_rs2, tv[k].f2);
      chk($sformatf("tv%0d rv", k), redirect_valid, tv[k].rv);
    end
    // load-use: one bubble, then MA load not forwardable, then WB forward
    apply(quiet(), 1'b1);
    x = quiet(); x.exrd = 6; x.exwe = 1; x.exsrc = RES_MEM; x.r1 = 6; x.u1 = 1;
    apply(x, 1'b0);
    chk("lu stall", stall, 5'b00011); chk("lu flush", flush, 5'b00100);
    x = quiet(); x.r1 = 6; x.u1 = 1; x.exr1 = 6; x.mrd = 6; x.mwe = 1; x.msrc = RES_MEM;
    apply(x, 1'b0);
    chk("lu2 stall", stall, 5'b00000); chk("lu2 fwd", forward_rs1, FWD_NONE);
    x = quiet(); x.exr1 = 6; x.wrd = 6; x.wwe = 1;
    apply(x, 1'b0);
    chk("lu3 fwd", forward_rs1, FWD_WB);
    // multi-cycle hold
    apply(quiet(), 1'b1);
    x = quiet(); x.mc = 1;
    for (int i = 0; i < 4; i++) begin
      apply(x, 1'b0);
      chk($sformatf("mc%0d stall", i), stall, i < 3 ? 5'b00111 : 5'b00000);
      chk($sformatf("mc%0d flush", i), flush, i < 3 ? 5'b01000 : 5'b00000);
    end
    // redirect while fetch waits
    apply(quiet(), 1'b1);
    x = quiet(); x.br = 1; x.tgt = 32'h100; x.imr = 0;
    apply(x, 1'b0);
    chk("rd0 flush", flush, 5'b00011); chk("rd0 stall", stall, 5'b00001);
    chk("rd0 rv", redirect_valid, 1); chk("rd0 pc", redirect_pc, 32'h100);
    x = quiet(); x.imr = 0; x.tgt = 32'hdead;
    apply(x, 1'b0);
    chk("rd1 rv", redirect_valid, 1); chk("rd1 pc", redirect_pc, 32'h100);
    x.imr = 1;
    apply(x, 1'b0);
    chk("rd2 rv", redirect_valid, 1); chk("rd2 pc", redirect_pc, 32'h100);
    apply(quiet(), 1'b0);
    chk("rd3 rv", redirect_valid, 0); chk("rd3 count", redirect_count, 1);
    // data memory wait with a taken branch in EX
    apply(quiet(), 1'b1);
    x = quiet(); x.dreq = 1; x.br = 1; x.tgt = 32'h200;
    for (int i = 0; i < 3; i++) begin
      apply(x, 1'b0);
      chk($sformatf("dm%0d stall", i), stall, 5'b11111);
      chk($sformatf("dm%0d flush", i), flush, 5'b00000);
      chk($sformatf("dm%0d rv", i), redirect_valid, 0);
    end
    x.drdy = 1;
    apply(x, 1'b0);
    chk("dm3 flush", flush, 5'b00011); chk("dm3 pc", redirect_pc, 32'h200);
    // reset in the middle of a multi-cycle hold with a pending redirect
    apply(quiet(), 1'b1);
    x = quiet(); x.br = 1; x.tgt = 32'h300; x.imr = 0;
    apply(x, 1'b0);
    x = quiet(); x.mc = 1; x.imr = 0;
    apply(x, 1'b0);
    chk("rs pend rv", redirect_valid, 1); chk("rs pend stall", stall, 5'b00111);
    apply(x, 1'b0);
    apply(x, 1'b1);
    x = quiet(); x.mc = 1;
    apply(x, 1'b0);
    chk("rs rv", redirect_valid, 0); chk("rs pc", redirect_pc, 0);
    chk("rs scyc", stall_cycles, 0); chk("rs rcnt", redirect_count, 0);
    chk("rs0 stall", stall, 5'b00111);
    apply(x, 1'b0);
    apply(x, 1'b0);
    chk("rs2 stall", stall, 5'b00111);
    apply(x, 1'b0);
    chk("rs3 stall", stall, 5'b00000);
    // randomized run against the model
    apply(quiet(), 1'b1);
    model_clk(quiet(), model(quiet()), 1'b1);
    x = quiet();
    for (int c = 0; c < 3000; c++) begin
      x.r1 = 5'($urandom_range(0, 3)); x.r2 = 5'($urandom_range(0, 3));
      x.exr1 = 5'($urandom_range(0, 3)); x.exr2 = 5'($urandom_range(0, 3));
      x.exrd = 5'($urandom_range(0, 3)); x.mrd = 5'($urandom_range(0, 3)); x.wrd = 5'($urandom_range(0, 3));
      x.u1 = 1'($urandom); x.u2 = 1'($urandom); x.exwe = 1'($urandom); x.mwe = 1'($urandom); x.wwe = 1'($urandom);
      x.exsrc = 2'($urandom_range(0, 2)); x.msrc = 2'($urandom_range(0, 2));
      x.mc = x.mc ? ($urandom % 4 != 0) : ($urandom % 6 == 0);
      x.br = ($urandom % 5 == 0); x.tgt = $urandom;
      x.imr = ($urandom % 4 != 0); x.dreq = ($urandom % 3 == 0); x.drdy = 1'($urandom);
      r = ($urandom % 300 == 0);
      apply(x, r);
      o = model(x);
      chk("rnd stall", stall, o.st);
      chk("rnd flush", flush, o.fl);
      chk("rnd fwd1", forward_rs1, o.f1);
      chk("rnd fwd2", forward_rs2, o.f2);
      chk("rnd rv", redirect_valid, o.rv);
      if (o.rv) chk("rnd pc", redirect_pc, o.rpc);
      chk("rnd scyc", stall_cycles, m_sc);
      chk("rnd rcnt", redirect_count, m_rc);
      model_clk(x, o, r);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
